// File: rtl/lsu_unit.sv
// lsu_unit: byte/half/word load-store unit for the memory stage.
// Holds the core via busy while a dmem request is outstanding.
module lsu_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  bus_err,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [1:0]            r_off;
  logic [2:0]            r_f3;
  logic                  r_st;

  logic                  legal;
  logic                  mis;
  logic [3:0]            be_n;
  logic [DATA_WIDTH-1:0] wd_n;
  logic [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] shv;
  logic [7:0]            bv;
  logic [15:0]           hv;

  assign busy = (state != IDLE) | start;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !is_store;
      default:                legal = 1'b0;
    endcase
  end

  assign mis = ((funct3[1:0] == 2'b01) & addr[0])
             | ((funct3[1:0] == 2'b10) & (|addr[1:0]));

  always_comb begin
    be_n = 4'b0000;
    wd_n = '0;
    case (funct3[1:0])
      2'b00: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{store_data[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = store_data;
      end
    endcase
  end

  // lane select uses the offset captured at issue, not the live addr
  assign shv = dmem_rdata >> {r_off, 3'b000};
  assign bv  = shv[7:0];
  assign hv  = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ext = dmem_rdata;
    case (r_f3)
      3'b000:  ext = {{(DATA_WIDTH-8){bv[7]}}, bv};
      3'b001:  ext = {{(DATA_WIDTH-16){hv[15]}}, hv};
      3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, bv};
      3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, hv};
      default: ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      r_off      <= 2'b00;
      r_f3       <= 3'b000;
      r_st       <= 1'b0;
      done       <= 1'b0;
      load_data  <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!legal) begin
              state   <= RESP;
              done    <= 1'b1;
              illegal <= 1'b1;
            end else if (mis) begin
              state      <= RESP;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state      <= REQ;
              cnt        <= CW'(1);
              r_off      <= addr[1:0];
              r_f3       <= funct3;
              r_st       <= is_store;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
              dmem_be    <= be_n;
              dmem_wdata <= is_store ? wd_n : '0;
            end
          end
        end
        REQ: begin
          if (dmem_ack || (TIMEOUT != 0 && cnt == TMAX)) begin
            state      <= RESP;
            done       <= 1'b1;
            bus_err    <= !dmem_ack;
            load_data  <= (dmem_ack && !r_st) ? ext : '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          cnt        <= '0;
          done       <= 1'b0;
          load_data  <= '0;
          misaligned <= 1'b0;
          illegal    <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
